// File: rtl/uart_mult_pkg.sv
// Shared types and framing constants for the UART multiply responder.
// Optional build macro: RESP_CHECKSUM_EN (see uart_mult_responder.sv).
package uart_mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_A,
      RX_B,
      RX_END,
      MUL,
      TX_LOAD,
      TX_ACK
   } state_t;

   localparam logic [7:0] STX  = 8'h02;
   localparam logic [7:0] TERM = 8'h0A;
   localparam logic [7:0] NAK  = 8'h15;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier, one partial product per clock.
// done is high during the last step; product is valid while done is high.
module seq_multiplier #(
   parameter int OP_WIDTH = 8
) (
   input  logic                  clk_int,
   input  logic                  uart_reset,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   a,
   input  logic [OP_WIDTH-1:0]   b,
   output logic                  done,
   output logic [2*OP_WIDTH-1:0] product
);

   localparam int CW = $clog2(OP_WIDTH + 1);

   logic [2*OP_WIDTH-1:0] mcand;
   logic [2*OP_WIDTH-1:0] acc;
   logic [2*OP_WIDTH-1:0] pp;
   logic [OP_WIDTH-1:0]   mplier;
   logic [CW-1:0]         cnt;

   assign pp      = mplier[0] ? mcand : '0;
   assign product = acc + pp;
   assign done    = (cnt == CW'(1));

   always_ff @(posedge clk_int or posedge uart_reset) begin
      if (uart_reset) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= {{OP_WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         cnt    <= CW'(OP_WIDTH);
      end else if (cnt != '0) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/uart_mult_responder.sv
// Frame parser, multiplier launch and byte streamer behind uart_rx_tx.
// Define RESP_CHECKSUM_EN to append an XOR checksum byte to product replies.
module uart_mult_responder #(
   parameter int OP_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk_int,
   input  logic                  uart_reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  tx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   output logic                  busy,
   output logic [2*OP_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic                  frame_err
);

   import uart_mult_pkg::*;

   localparam int NB  = OP_WIDTH / 8;
`ifdef RESP_CHECKSUM_EN
   localparam int NTX = 2 * NB + 1;
`else
   localparam int NTX = 2 * NB;
`endif
   localparam int BW  = $clog2(NB + 1);
   localparam int TW  = $clog2(NTX + 1);
   localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

   state_t                state, state_nxt;
   logic [OP_WIDTH-1:0]   op_a, op_b;
   logic [BW-1:0]         byte_cnt;
   logic [TW-1:0]         tx_idx;
   logic [CW-1:0]         tmo_cnt;
   logic                  nak;
   logic                  mul_start, mul_done;
   logic [2*OP_WIDTH-1:0] mul_product;
   logic                  in_rx, tmo_hit, op_last, tx_last;
   logic [7:0]            tx_byte;

   assign in_rx     = (state == RX_A) || (state == RX_B) || (state == RX_END);
   assign tmo_hit   = in_rx && !rx_valid && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign op_last   = (byte_cnt == BW'(NB - 1));
   assign tx_last   = nak || (tx_idx == TW'(NTX - 1));
   assign mul_start = (state == RX_END) && rx_valid && (rx_data == TERM);
   assign busy      = (state != IDLE);
   assign tx_start  = (state == TX_ACK);

   seq_multiplier #(.OP_WIDTH(OP_WIDTH)) u_mul (
      .clk_int    (clk_int),
      .uart_reset (uart_reset),
      .start      (mul_start),
      .a          (op_a),
      .b          (op_b),
      .done       (mul_done),
      .product    (mul_product)
   );

   always_comb begin
      tx_byte = '0;
      for (int i = 0; i < 2 * NB; i++)
         if (tx_idx == TW'(i))
            tx_byte = result[(2*NB-1-i)*8 +: 8];
`ifdef RESP_CHECKSUM_EN
      if (tx_idx == TW'(2 * NB)) begin
         tx_byte = '0;
         for (int i = 0; i < 2 * NB; i++)
            tx_byte = tx_byte ^ result[i*8 +: 8];
      end
`endif
      if (nak)
         tx_byte = NAK;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_valid && rx_data == STX) state_nxt = RX_A;
         RX_A:    if (tmo_hit) state_nxt = IDLE;
                  else if (rx_valid && op_last) state_nxt = RX_B;
         RX_B:    if (tmo_hit) state_nxt = IDLE;
                  else if (rx_valid && op_last) state_nxt = RX_END;
         RX_END:  if (tmo_hit) state_nxt = IDLE;
                  else if (rx_valid)
                     state_nxt = (rx_data == TERM) ? MUL : TX_LOAD;
         MUL:     if (mul_done) state_nxt = TX_LOAD;
         TX_LOAD: if (tx_ready) state_nxt = TX_ACK;
         TX_ACK:  if (!tx_ready) state_nxt = tx_last ? IDLE : TX_LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_int or posedge uart_reset) begin
      if (uart_reset) begin
         state        <= IDLE;
         op_a         <= '0;
         op_b         <= '0;
         byte_cnt     <= '0;
         tx_idx       <= '0;
         tmo_cnt      <= '0;
         nak          <= 1'b0;
         tx_data      <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state        <= state_nxt;
         result_valid <= 1'b0;
         frame_err    <= tmo_hit;
         // The idle counter only runs inside a frame; any byte reloads it.
         if (in_rx && !rx_valid)
            tmo_cnt <= tmo_cnt + CW'(1);
         else
            tmo_cnt <= '0;
         case (state)
            IDLE: byte_cnt <= '0;
            RX_A:
               if (rx_valid) begin
                  op_a     <= (op_a << 8) | OP_WIDTH'(rx_data);
                  byte_cnt <= op_last ? '0 : byte_cnt + BW'(1);
               end
            RX_B:
               if (rx_valid) begin
                  op_b     <= (op_b << 8) | OP_WIDTH'(rx_data);
                  byte_cnt <= op_last ? '0 : byte_cnt + BW'(1);
               end
            RX_END:
               if (rx_valid) begin
                  nak       <= (rx_data != TERM);
                  frame_err <= (rx_data != TERM);
                  tx_idx    <= '0;
               end
            MUL:
               if (mul_done) begin
                  result       <= mul_product;
                  result_valid <= 1'b1;
               end
            TX_LOAD: tx_data <= tx_byte;
            TX_ACK:
               if (!tx_ready && !tx_last)
                  tx_idx <= tx_idx + TW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mult_responder.sv
// Directed self-checking bench for uart_mult_responder (OP_WIDTH=8).
module tb_uart_mult_responder;

   localparam int OPW = 8;
   localparam int TMO = 40;
`ifdef RESP_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif

   logic        clk_int = 1'b0;
   logic        uart_reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        busy;
   logic [15:0] result;
   logic        result_valid;
   logic        frame_err;

   int checks   = 0;
   int failures = 0;
   int rv_cnt   = 0;
   int fe_cnt   = 0;
   int tx_gap   = 3;
   logic [7:0] txq[$];

   typedef struct packed {
      logic [31:0] rx;
      logic [15:0] tx;
      logic [15:0] res;
      logic        err;
   } vec_t;

   vec_t vecs[7];

   always #5 clk_int = ~clk_int;

   uart_mult_responder #(.OP_WIDTH(OPW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_int      (clk_int),
      .uart_reset   (uart_reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .frame_err    (frame_err)
   );

   always @(negedge clk_int) begin
      if (result_valid) rv_cnt++;
      if (frame_err) fe_cnt++;
   end

   // Transmitter model: accept on tx_start, stay busy tx_gap cycles.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(negedge clk_int);
         if (tx_start && tx_ready) begin
            txq.push_back(tx_data);
            tx_ready = 1'b0;
            repeat (tx_gap) @(negedge clk_int);
            tx_ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int unsigned act,
                        input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk_int);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f);
      for (int j = 0; j < 4; j++) begin
         send_byte(f[31-8*j -: 8]);
         if (j < 3) @(negedge clk_int);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 3000) begin
         @(negedge clk_int);
         k++;
      end
      check("idle_wait", busy, 0);
      repeat (tx_gap + 3) @(negedge clk_int);
   endtask

   task automatic wait_tx_start(input string name);
      int k = 0;
      while (!tx_start && k < 200) begin
         @(negedge clk_int);
         k++;
      end
      check(name, tx_start, 1);
   endtask

   task automatic check_tx(input string tag, input logic [15:0] prod,
                           input logic err);
      int nexp;
      logic [7:0] eb;
      int ab;
      nexp = err ? 1 : 2 + CSUM;
      check({tag, "_tx_count"}, txq.size(), nexp);
      for (int k = 0; k < nexp; k++) begin
         if (err) eb = 8'h15;
         else if (k == 0) eb = prod[15:8];
         else if (k == 1) eb = prod[7:0];
         else eb = prod[15:8] ^ prod[7:0];
         ab = (k < txq.size()) ? int'(txq[k]) : 'h100;
         check({tag, "_tx_byte"}, ab, eb);
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] rx,
                          input logic [15:0] tx, input logic [15:0] res,
                          input logic err);
      vecs[i].rx  = rx;
      vecs[i].tx  = tx;
      vecs[i].res = res;
      vecs[i].err = err;
   endtask

   initial begin
      int rv0, fe0, lat;
      set_vec(0, 32'h0203050A, 16'h000F, 16'h000F, 1'b0);
      set_vec(1, 32'h02FFFF0A, 16'hFE01, 16'hFE01, 1'b0);
      set_vec(2, 32'h0203050B, 16'h0000, 16'hFE01, 1'b1);
      set_vec(3, 32'h02020A0A, 16'h0014, 16'h0014, 1'b0);
      set_vec(4, 32'h0207060A, 16'h002A, 16'h002A, 1'b0);
      set_vec(5, 32'h0200FF0A, 16'h0000, 16'h0000, 1'b0);
      set_vec(6, 32'h0280020A, 16'h0100, 16'h0100, 1'b0);

      uart_reset = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      repeat (3) @(negedge clk_int);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_result", result, 0);
      check("rst_flags", {result_valid, frame_err}, 0);
      uart_reset = 1'b0;
      @(negedge clk_int);

      // Non-STX bytes in IDLE are ignored.
      fe0 = fe_cnt;
      send_byte(8'h0A);
      send_byte(8'h55);
      send_byte(8'h03);
      check("idle_ignore_busy", busy, 0);
      repeat (5) @(negedge clk_int);
      check("idle_ignore_tx", txq.size(), 0);
      check("idle_ignore_err", fe_cnt - fe0, 0);

      for (int i = 0; i < 7; i++) begin
         txq.delete();
         rv0 = rv_cnt;
         fe0 = fe_cnt;
         send_frame(vecs[i].rx);
         if (!vecs[i].err) begin
            lat = 0;
            while (!result_valid && lat < 50) begin
               @(negedge clk_int);
               lat++;
            end
            check("mul_latency", lat, OPW);
         end
         wait_idle();
         check_tx("vec", vecs[i].tx, vecs[i].err);
         check("vec_result", result, vecs[i].res);
         check("vec_rv_pulses", rv_cnt - rv0, vecs[i].err ? 0 : 1);
         check("vec_err_pulses", fe_cnt - fe0, vecs[i].err ? 1 : 0);
      end

      // Timeout mid-frame: abort silently apart from frame_err.
      txq.delete();
      fe0 = fe_cnt;
      send_byte(8'h02);
      send_byte(8'h03);
      repeat (TMO - 5) @(negedge clk_int);
      check("tmo_early_busy", busy, 1);
      wait_idle();
      check("tmo_err_pulses", fe_cnt - fe0, 1);
      check("tmo_tx_count", txq.size(), 0);
      check("tmo_result_kept", result, 16'h0100);

      // A byte on the terminal-count cycle reloads the counter.
      txq.delete();
      fe0 = fe_cnt;
      send_byte(8'h02);
      repeat (TMO - 1) @(negedge clk_int);
      send_byte(8'h04);
      send_byte(8'h03);
      send_byte(8'h0A);
      wait_idle();
      check("tmo_edge_err", fe_cnt - fe0, 0);
      check_tx("tmo_edge", 16'h000C, 1'b0);

      // Bytes arriving while transmitting are dropped.
      tx_gap = 6;
      txq.delete();
      fe0 = fe_cnt;
      send_frame(32'h0207060A);
      wait_tx_start("drop_tx_start");
      send_byte(8'h02);
      send_byte(8'h11);
      wait_idle();
      check("drop_err", fe_cnt - fe0, 0);
      check_tx("drop", 16'h002A, 1'b0);
      tx_gap = 3;

      // Reset in TX_ACK clears outputs at once.
      send_frame(32'h0203050A);
      wait_tx_start("rst_ack_tx_start");
      uart_reset = 1'b1;
      #1;
      check("rst_ack_tx_start_low", tx_start, 0);
      check("rst_ack_busy", busy, 0);
      check("rst_ack_tx_data", tx_data, 0);
      check("rst_ack_result", result, 0);
      @(negedge clk_int);
      uart_reset = 1'b0;
      repeat (10) @(negedge clk_int);
      txq.delete();
      fe0 = fe_cnt;
      send_frame(32'h020C0B0A);
      wait_idle();
      check_tx("post_rst", 16'h0084, 1'b0);
      check("post_rst_result", result, 16'h0084);
      check("post_rst_err", fe_cnt - fe0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
